// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny gradient path (grad_pack_tx, nms_core).
package canny_pkg;

    // Quantized gradient direction bins.
    typedef enum logic [2:0] {
        DIR_H   = 3'd0,
        DIR_45  = 3'd1,
        DIR_V   = 3'd2,
        DIR_135 = 3'd3
    } dir_e;

    // Packed stream word layout: {1'b0, dir[2:0], mag[11:0]}.
    localparam int TDATA_WIDTH = 16;
    localparam int MAG_LSB     = 0;
    localparam int DIR_LSB     = 12;

    // tan(22.5) ~= 53/128 and tan(67.5) ~= 309/128.
    localparam int TAN22_NUM     = 53;
    localparam int TAN67_NUM     = 309;
    localparam int TAN_DEN_SHIFT = 7;

    // Framing flags computed at input time and carried with each beat.
    typedef struct packed {
        logic sof;  // row 0, col 0
        logic eol;  // last column of a line
        logic eof;  // last column of the last line
    } frame_flags_t;

endpackage

// File: rtl/grad_pack_tx_if.sv
// Gradient input stream plus packed AXI-Stream output of grad_pack_tx.
// Handshake: a beat moves on a rising clk edge where valid & ready are both 1;
// a producer holds valid and its payload stable until that edge, and ready
// may depend combinationally on the consumer's own downstream ready.
interface grad_pack_tx_if #(
    parameter int GRAD_WIDTH = 12
) ();
    logic signed [GRAD_WIDTH-1:0]           s_gx;
    logic signed [GRAD_WIDTH-1:0]           s_gy;
    logic                                   s_valid;
    logic                                   s_ready;
    logic                                   frame_restart;
    logic [canny_pkg::TDATA_WIDTH-1:0]      m_tdata;
    logic                                   m_tvalid;
    logic                                   m_tuser;
    logic                                   m_tlast;
    logic                                   m_teof;
    logic                                   m_tready;

    // Upstream/downstream environment view.
    modport master (
        output s_gx, s_gy, s_valid, frame_restart, m_tready,
        input  s_ready, m_tdata, m_tvalid, m_tuser, m_tlast, m_teof
    );

    // grad_pack_tx view.
    modport slave (
        input  s_gx, s_gy, s_valid, frame_restart, m_tready,
        output s_ready, m_tdata, m_tvalid, m_tuser, m_tlast, m_teof
    );
endinterface

// File: rtl/grad_quantizer.sv
// Combinational magnitude/direction logic, split at the S1/S2 register
// boundary. The front half feeds the S1 registers, the back half reads them.
module grad_quantizer
    import canny_pkg::*;
#(
    parameter  int GRAD_WIDTH = 12,
    parameter  int MAG_WIDTH  = 12,
    parameter  int DIR_WIDTH  = 3,
    localparam int PROD_WIDTH = 2 * GRAD_WIDTH + 1
) (
    // front half: raw gradients in, S1 register values out
    input  logic signed [GRAD_WIDTH-1:0] gx,
    input  logic signed [GRAD_WIDTH-1:0] gy,
    output logic [GRAD_WIDTH-1:0]        ax,
    output logic [GRAD_WIDTH-1:0]        ay,
    output logic [PROD_WIDTH-1:0]        ay_scaled,
    output logic [PROD_WIDTH-1:0]        ax_tan22,
    output logic [PROD_WIDTH-1:0]        ax_tan67,
    output logic                         same_sign,
    // back half: S1 register values in, packed word out
    input  logic [GRAD_WIDTH-1:0]        s1_ax,
    input  logic [GRAD_WIDTH-1:0]        s1_ay,
    input  logic [PROD_WIDTH-1:0]        s1_ay_scaled,
    input  logic [PROD_WIDTH-1:0]        s1_ax_tan22,
    input  logic [PROD_WIDTH-1:0]        s1_ax_tan67,
    input  logic                         s1_same_sign,
    output logic [TDATA_WIDTH-1:0]       tdata
);
    logic [GRAD_WIDTH-1:0] gx_u;
    logic [GRAD_WIDTH-1:0] gy_u;
    logic [GRAD_WIDTH:0]   mag_sum;
    logic [MAG_WIDTH-1:0]  mag;
    dir_e                  dir;

    localparam logic [GRAD_WIDTH:0] MAG_MAX = (GRAD_WIDTH + 1)'((1 << MAG_WIDTH) - 1);

    assign gx_u = gx;
    assign gy_u = gy;

    // Front half: absolute values (the most negative input maps to its
    // unsigned magnitude), scaled comparison operands and sign agreement.
    always_comb begin
        ax        = gx[GRAD_WIDTH-1] ? (~gx_u + GRAD_WIDTH'(1)) : gx_u;
        ay        = gy[GRAD_WIDTH-1] ? (~gy_u + GRAD_WIDTH'(1)) : gy_u;
        ay_scaled = PROD_WIDTH'(ay) << TAN_DEN_SHIFT;
        ax_tan22  = PROD_WIDTH'(ax) * PROD_WIDTH'(TAN22_NUM);
        ax_tan67  = PROD_WIDTH'(ax) * PROD_WIDTH'(TAN67_NUM);
        same_sign = (gx[GRAD_WIDTH-1] == gy[GRAD_WIDTH-1]);
    end

    // Back half: saturated L1 magnitude, bin select and packing.
    always_comb begin
        mag_sum = {1'b0, s1_ax} + {1'b0, s1_ay};
        if (mag_sum > MAG_MAX) mag = '1;
        else                   mag = MAG_WIDTH'(mag_sum);

        if (s1_ay_scaled <= s1_ax_tan22)      dir = DIR_H;
        else if (s1_ay_scaled >= s1_ax_tan67) dir = DIR_V;
        else if (s1_same_sign)                dir = DIR_45;
        else                                  dir = DIR_135;

        tdata = '0;
        tdata[DIR_LSB +: DIR_WIDTH] = DIR_WIDTH'(dir);
        tdata[MAG_LSB +: MAG_WIDTH] = mag;
    end
endmodule

// File: rtl/grad_pack_tx.sv
// Packs signed Sobel gradients into the NMS gradient stream: two-stage
// elastic pipeline, counter-generated framing and an end-of-frame level.
module grad_pack_tx
    import canny_pkg::*;
#(
    parameter int GRAD_WIDTH = 12,
    parameter int MAG_WIDTH  = 12,
    parameter int DIR_WIDTH  = 3,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic           clk,
    input  logic           rst_n,
    grad_pack_tx_if.slave  bus
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW    = 2 * GRAD_WIDTH + 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    frame_flags_t     in_flags;

    // quantizer front-half outputs
    logic [GRAD_WIDTH-1:0] q_ax, q_ay;
    logic [PW-1:0]         q_ay_scaled, q_ax_tan22, q_ax_tan67;
    logic                  q_same_sign;
    logic [TDATA_WIDTH-1:0] q_tdata;

    // S1 registers
    logic                  s1_valid;
    logic [GRAD_WIDTH-1:0] s1_ax, s1_ay;
    logic [PW-1:0]         s1_ay_scaled, s1_ax_tan22, s1_ax_tan67;
    logic                  s1_same_sign;
    frame_flags_t          s1_flags;

    // S2 (output) registers
    logic                   m_tvalid_q;
    logic [TDATA_WIDTH-1:0] m_tdata_q;
    logic                   m_tuser_q;
    logic                   m_tlast_q;
    logic                   m_eof_q;
    logic                   m_teof_q;

    logic s2_advance, s1_load, in_accept, out_accept, restart;

    assign restart    = bus.frame_restart;
    assign s2_advance = ~m_tvalid_q | bus.m_tready;
    assign s1_load    = ~s1_valid | s2_advance;
    assign bus.s_ready = s1_load & ~restart;
    assign in_accept  = bus.s_valid & bus.s_ready;
    assign out_accept = m_tvalid_q & bus.m_tready;

    assign in_flags.sof = (col == '0) && (row == '0);
    assign in_flags.eol = (col == COL_W'(IMG_WIDTH - 1));
    assign in_flags.eof = in_flags.eol && (row == ROW_W'(IMG_HEIGHT - 1));

    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tuser  = m_tuser_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_teof   = m_teof_q;

    grad_quantizer #(
        .GRAD_WIDTH (GRAD_WIDTH),
        .MAG_WIDTH  (MAG_WIDTH),
        .DIR_WIDTH  (DIR_WIDTH)
    ) u_quant (
        .gx           (bus.s_gx),
        .gy           (bus.s_gy),
        .ax           (q_ax),
        .ay           (q_ay),
        .ay_scaled    (q_ay_scaled),
        .ax_tan22     (q_ax_tan22),
        .ax_tan67     (q_ax_tan67),
        .same_sign    (q_same_sign),
        .s1_ax        (s1_ax),
        .s1_ay        (s1_ay),
        .s1_ay_scaled (s1_ay_scaled),
        .s1_ax_tan22  (s1_ax_tan22),
        .s1_ax_tan67  (s1_ax_tan67),
        .s1_same_sign (s1_same_sign),
        .tdata        (q_tdata)
    );

    // Column/row position of the next accepted input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (restart) begin
            col <= '0;
            row <= '0;
        end else if (in_accept) begin
            if (in_flags.eol) begin
                col <= '0;
                row <= in_flags.eof ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // S1: capture abs values, products, sign compare and framing flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_ax        <= '0;
            s1_ay        <= '0;
            s1_ay_scaled <= '0;
            s1_ax_tan22  <= '0;
            s1_ax_tan67  <= '0;
            s1_same_sign <= 1'b0;
            s1_flags     <= '0;
        end else if (restart) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_accept;
            if (in_accept) begin
                s1_ax        <= q_ax;
                s1_ay        <= q_ay;
                s1_ay_scaled <= q_ay_scaled;
                s1_ax_tan22  <= q_ax_tan22;
                s1_ax_tan67  <= q_ax_tan67;
                s1_same_sign <= q_same_sign;
                s1_flags     <= in_flags;
            end
        end
    end

    // S2: output register; holds its beat while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_eof_q    <= 1'b0;
        end else if (restart) begin
            m_tvalid_q <= 1'b0;
        end else if (s2_advance) begin
            m_tvalid_q <= s1_valid;
            if (s1_valid) begin
                m_tdata_q <= q_tdata;
                m_tuser_q <= s1_flags.sof;
                m_tlast_q <= s1_flags.eol;
                m_eof_q   <= s1_flags.eof;
            end
        end
    end

    // End-of-frame level: rises after the last beat of a frame leaves,
    // falls when the next frame's first beat leaves or on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_teof_q <= 1'b0;
        end else if (restart) begin
            m_teof_q <= 1'b0;
        end else if (out_accept && m_eof_q) begin
            m_teof_q <= 1'b1;
        end else if (out_accept && m_tuser_q) begin
            m_teof_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_grad_pack_tx.sv
// Self-checking bench for grad_pack_tx with a 4x2 image.
module tb_grad_pack_tx;

    localparam int W = 4;
    localparam int H = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grad_pack_tx_if #(.GRAD_WIDTH(12)) bus ();

    grad_pack_tx #(
        .GRAD_WIDTH (12),
        .MAG_WIDTH  (12),
        .DIR_WIDTH  (3),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- stimulus vectors (hand-computed words) ----------------
    logic signed [11:0] vec_gx [12] = '{12'sd100, 12'sd100, -12'sd100, 12'sd0,
                                        12'sd128, 12'sd128, -12'sd2048, -12'sd300,
                                        12'sd5, 12'sd128, 12'sd128, 12'sd2047};
    logic signed [11:0] vec_gy [12] = '{12'sd0, 12'sd100, 12'sd100, -12'sd50,
                                        12'sd53, 12'sd54, -12'sd2048, -12'sd40,
                                        -12'sd2047, 12'sd309, -12'sd308, -12'sd2048};
    logic [15:0]        vec_td [12] = '{16'h0064, 16'h10C8, 16'h30C8, 16'h2032,
                                        16'h00B5, 16'h10B6, 16'h1FFF, 16'h0154,
                                        16'h2804, 16'h21B5, 16'h31B4, 16'h3FFF};

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] exp_q [$];   // {eof, tuser, tlast, tdata}
    int mcol = 0;
    int mrow = 0;
    int ready_mode = 0;       // 0: ready high, 1: random, 2: ready low
    logic exp_teof = 1'b0;
    logic stall_prev = 1'b0;
    logic [17:0] prev_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- downstream ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.m_tready = 1'b1;
            1:       bus.m_tready = 1'($urandom_range(0, 1));
            default: bus.m_tready = 1'b0;
        endcase
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [18:0] ent;
        logic next_teof;
        if (!rst_n) begin
            stall_prev = 1'b0;
            exp_teof   = 1'b0;
        end else begin
            check("teof", bus.m_teof, exp_teof);
            if (stall_prev)
                check("stall_stable", {bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata},
                      {1'b1, prev_word});
            next_teof = exp_teof;
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check("beat", {bus.m_tuser, bus.m_tlast, bus.m_tdata}, ent[17:0]);
                    if (ent[18])      next_teof = 1'b1;
                    else if (ent[17]) next_teof = 1'b0;
                end
            end
            if (bus.frame_restart) begin
                next_teof  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                stall_prev = bus.m_tvalid && !bus.m_tready;
                prev_word  = {bus.m_tuser, bus.m_tlast, bus.m_tdata};
            end
            exp_teof = next_teof;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        exp_q.delete();
        mcol = 0;
        mrow = 0;
    endtask

    task automatic push_expected(input int idx);
        logic sof, eol, eof;
        sof = (mcol == 0) && (mrow == 0);
        eol = (mcol == W - 1);
        eof = eol && (mrow == H - 1);
        exp_q.push_back({eof, sof, eol, vec_td[idx]});
        if (eol) begin
            mcol = 0;
            mrow = eof ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    // Entered and left at posedge+1; leaves s_valid high for back-to-back use.
    task automatic send_beat(input int idx);
        bit accepted = 0;
        int waited = 0;
        bus.s_gx = vec_gx[idx];
        bus.s_gy = vec_gy[idx];
        bus.s_valid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (bus.s_ready) begin
                push_expected(idx);
                accepted = 1;
            end
            @(posedge clk); #1;
            waited++;
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.frame_restart = 1'b0;
        #1;
        check("rst_tdata", bus.m_tdata, 32'd0);
        check("rst_tvalid", bus.m_tvalid, 32'd0);
        check("rst_tuser", bus.m_tuser, 32'd0);
        check("rst_tlast", bus.m_tlast, 32'd0);
        check("rst_teof", bus.m_teof, 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain();
        int waited = 0;
        bus.s_valid = 1'b0;
        ready_mode = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            step();
            waited++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.s_gx = '0;
        bus.s_gy = '0;
        bus.s_valid = 1'b0;
        bus.frame_restart = 1'b0;
        bus.m_tready = 1'b1;

        do_reset();

        // single beats: latency and the directed/boundary vectors
        for (int i = 0; i < 7; i++) begin
            send_beat(i);
            bus.s_valid = 1'b0;
            @(negedge clk);
            check("lat_c1_valid", bus.m_tvalid, 32'd0);
            step();
            @(negedge clk);
            check("lat_c2_valid", bus.m_tvalid, 32'd1);
            check("lat_c2_data", bus.m_tdata, {16'd0, vec_td[i]});
            step();
        end
        drain();

        // full frame back-to-back, then end-of-frame level
        do_reset();
        for (int k = 0; k < 8; k++) send_beat(k);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("eof_early", bus.m_teof, 32'd0);
        step();
        @(negedge clk);
        check("eof_last_beat", {bus.m_tvalid, bus.m_tlast}, 32'h3);
        step();
        @(negedge clk);
        check("eof_rise", bus.m_teof, 32'd1);
        repeat (2) step();
        @(negedge clk);
        check("eof_level", bus.m_teof, 32'd1);
        step();
        send_beat(8);
        bus.s_valid = 1'b0;
        step();
        @(negedge clk);
        check("eof_hold_sof", {bus.m_tvalid, bus.m_tuser, bus.m_teof}, 32'h7);
        step();
        @(negedge clk);
        check("eof_fall", bus.m_teof, 32'd0);
        drain();

        // three frames with random downstream ready
        do_reset();
        ready_mode = 1;
        for (int k = 0; k < 3 * W * H; k++) begin
            send_beat(k % 12);
            if ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                step();
            end
        end
        drain();

        // frame_restart after five beats
        do_reset();
        for (int k = 0; k < 5; k++) send_beat(k);
        bus.s_gx = vec_gx[9];
        bus.s_gy = vec_gy[9];
        bus.s_valid = 1'b1;
        bus.frame_restart = 1'b1;
        @(negedge clk);
        check("restart_s_ready", bus.s_ready, 32'd0);
        step();
        bus.frame_restart = 1'b0;
        bus.s_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check("restart_flush", bus.m_tvalid, 32'd0);
        step();
        send_beat(5);
        bus.s_valid = 1'b0;
        step();
        @(negedge clk);
        check("restart_sof", {bus.m_tvalid, bus.m_tuser}, 32'h3);
        step();
        for (int k = 6; k < 12; k++) send_beat(k);
        drain();

        // reset mid-line with a stalled valid beat
        ready_mode = 2;
        step();
        send_beat(0);
        send_beat(1);
        bus.s_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("pre_rst_valid", bus.m_tvalid, 32'd1);
        do_reset();
        ready_mode = 0;
        step();
        send_beat(2);
        bus.s_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_rst_sof", {bus.m_tvalid, bus.m_tuser}, 32'h3);
        step();
        drain();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- time bound ----------------
    initial begin
        #200000;
        check("watchdog", 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grad_pack_tx.md
# grad_pack_tx

Transmit end of the packed gradient stream consumed by the NMS stage. Accepts raw signed Sobel gradients (gx, gy) on a valid/ready interface and computes saturated L1 magnitude and a quantized 4-bin direction. Emits an AXI-Stream whose framing is generated from internal column/row counters: `tuser` on the first pixel of a frame, `tlast` on the last pixel of each line, and a `teof` level after each frame. Sits between the Sobel convolver and `nms_stage`.

## Interface
- `GRAD_WIDTH`, 12: signed width of gx/gy.
- `MAG_WIDTH`, 12: magnitude field width, tdata[11:0].
- `DIR_WIDTH`, 3: direction field width, tdata[14:12].
- `IMG_WIDTH`, 1920: pixels per line.
- `IMG_HEIGHT`, 1080: lines per frame.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_gx` in GRAD_WIDTH: signed horizontal gradient.
- `s_gy` in GRAD_WIDTH: signed vertical gradient.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid & s_ready`.
- `frame_restart` in 1: synchronous pulse that clears the counters and flushes the pipeline.
- `m_tdata` out 16: {1'b0, dir[2:0], mag[11:0]}.
- `m_tvalid` out 1: output beat valid.
- `m_tuser` out 1: start of frame (row 0, col 0).
- `m_tlast` out 1: end of line (col IMG_WIDTH-1).
- `m_teof` out 1: end-of-frame level.
- `m_tready` in 1: downstream ready.

## Operation
- Magnitude is `|gx| + |gy|`, computed at GRAD_WIDTH+1 bits and saturated to 4095. `|-2048|` = 2048.
- Direction codes, with ax=|gx| and ay=|gy|:
  - 0 (horizontal) if `ay*128 <= ax*53`.
  - 2 (vertical) if `ay*128 >= ax*309`.
  - Otherwise 1 (45°) if sign(gx)==sign(gy), else 3 (135°). Zero counts as positive.
  - Code 0 when gx=gy=0.
  - Bit 2 of the direction field is always 0.
  - Products are computed at 2*GRAD_WIDTH+1 bits, unsigned.
- Framing counters `col` and `row` advance on each input accept:
  - `col` wraps at IMG_WIDTH-1. `row` increments on the `col` wrap and wraps at IMG_HEIGHT-1.
  - The tuser/tlast/eof flags are computed at input and carried with the data through the pipeline.
- `m_teof`:
  - Set the cycle after the output beat carrying row H-1 / col W-1 is accepted.
  - Cleared when the next `m_tuser` beat is accepted, on `frame_restart`, or on reset.
  - Never high together with an in-flight beat of the same frame.
- `frame_restart`:
  - Zeroes `col` and `row` and invalidates both pipeline stages (m_tvalid=0 next cycle).
  - Clears `m_teof`.
  - `s_ready` is forced to 0 during the restart cycle.
- Reset: all outputs 0 (`m_tdata`=0, `m_tvalid`=0, `m_tuser`=0, `m_tlast`=0, `m_teof`=0). Counters are 0 and both stages invalid. Reset mid-frame discards in-flight beats; the next accepted beat is row 0 / col 0.

## Timing
- Two register stages:
  - S1: abs values, products, sign compare, flags.
  - S2: saturation, bin select, pack. S2 is the output register.
- Latency: an input accepted at cycle N appears on `m_*` at N+2 when `m_tready` is held high.
- Throughput: 1 beat/cycle.
- Each stage loads when it is empty or the downstream stage is advancing. `s_ready = ~S1_valid | S2_advance`, where `S2_advance = ~m_tvalid | m_tready`. A combinational path from `m_tready` to `s_ready` is permitted.
- AXI rules: with `m_tready`=0, all `m_*` except `m_teof` hold stable. `m_tvalid` does not drop without acceptance.
- Full pipeline with `m_tready` low: `s_ready` is 0 and no data is lost or duplicated.
- Input accept and output accept in the same cycle: both take effect and the pipeline slides.

## Structure
- `canny_pkg`:
  - Direction code constants (DIR_H=0, DIR_45=1, DIR_V=2, DIR_135=3).
  - tdata field positions (MAG_LSB=0, DIR_LSB=12).
  - Quantizer constants TAN22_NUM=53, TAN67_NUM=309, TAN_DEN_SHIFT=7. These are shared with `nms_core`.
- Sub-module `grad_quantizer`: combinational abs/saturate/bin logic, split at the S1/S2 boundary with its registers owned by the top level.
- Top level holds the counters, pipeline valid/ready logic, and the teof register.

## Test plan
- Reset, then single beats with IMG 4x2 and `m_tready`=1:
  - gx=100,gy=0 -> 0x0064.
  - gx=100,gy=100 -> 0x10C8.
  - gx=-100,gy=100 -> 0x30C8.
  - gx=0,gy=-50 -> 0x2032.
  - Each appears 2 cycles after accept.
- Boundaries: gx=128,gy=53 -> dir 0. gx=128,gy=54 -> dir 1. gx=-2048,gy=-2048 -> 0x1FFF (saturated).
- Full 4x2 frame of 8 beats:
  - `m_tuser` only on beat 0. `m_tlast` on beats 3 and 7.
  - `m_teof` rises the cycle after beat 7 is accepted and falls when the next frame's beat 0 is accepted.
- Random `m_tready` (50%) over 3 frames of 4x2: the output sequence equals the scoreboard exactly, with no drops or duplicates and `m_tdata` stable while stalled.
- `frame_restart` pulsed after 5 beats: the next accepted beat carries `m_tuser`=1. Beats in flight at the restart are not emitted, and `m_teof` stays 0.
- `rst_n` asserted mid-line with `m_tvalid`=1: all outputs are 0 immediately. After release, the first beat carries `m_tuser`=1.
